// File: rtl/disp_share_arb.sv
// disp_share_arb
// Round-robin arbiter sharing one 8-digit seven-segment display between four
// requesters. A granted requester's 32-bit value is latched onto o_bits and
// held for at least HOLD_CLOCKS cycles so the message stays readable.
//
// Ports:
//   clk              system clock, all state on rising edge
//   i_rst            asynchronous active-high reset
//   i_req[3:0]       level request per requester (bit k = requester k)
//   i_data0..3       32-bit value offered by each requester
//   o_bits[31:0]     value currently displayed (registered)
//   o_owner[1:0]     index of the current or last owner (registered)
//   o_ack[3:0]       one-hot, one-cycle pulse: requester's data was latched
//   o_busy           high while a dwell is in progress
module disp_share_arb #(
  parameter int HOLD_CLOCKS = 50_000_000
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [3:0]  i_req,
  input  logic [31:0] i_data0,
  input  logic [31:0] i_data1,
  input  logic [31:0] i_data2,
  input  logic [31:0] i_data3,
  output logic [31:0] o_bits,
  output logic [1:0]  o_owner,
  output logic [3:0]  o_ack,
  output logic        o_busy
);

  localparam int CW = $clog2(HOLD_CLOCKS + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CLOCKS - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q;
  logic [CW-1:0]   holdCount_q;
  logic [1:0]      last_q;

  logic [31:0]     dataArr [4];
  logic [3:0]      effReq;
  logic [1:0]      winner;
  logic [1:0]      scanIdx;
  logic            found;
  logic            doGrant;

  // Gather the four offered values so they can be indexed by owner/winner.
  always_comb begin
    dataArr[0] = i_data0;
    dataArr[1] = i_data1;
    dataArr[2] = i_data2;
    dataArr[3] = i_data3;
  end

  // Mask the requester acked this cycle so a requester that drops its
  // request after seeing ack is never granted twice. The scan starts just
  // past the last owner, so the previous owner ends up with lowest priority.
  always_comb begin
    effReq  = i_req & ~o_ack;
    winner  = '0;
    scanIdx = '0;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      scanIdx = last_q + 2'(i);
      if (!found && effReq[scanIdx]) begin
        winner = scanIdx;
        found  = 1'b1;
      end
    end
  end

  // A new grant happens from IDLE, or back-to-back when a dwell expires.
  assign doGrant = found && ((state_q == IDLE) || (holdCount_q == '0));

  // Arbiter FSM with all outputs registered. o_ack defaults to zero every
  // edge and is only set on a grant or an owner refresh.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      holdCount_q <= '0;
      last_q      <= 2'd3;
      o_bits      <= '0;
      o_owner     <= '0;
      o_ack       <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_ack <= '0;
      if (doGrant) begin
        state_q     <= HOLD;
        holdCount_q <= RELOAD;
        last_q      <= winner;
        o_bits      <= dataArr[winner];
        o_owner     <= winner;
        o_ack       <= 4'b0001 << winner;
        o_busy      <= 1'b1;
      end else if (state_q == HOLD) begin
        if (holdCount_q != '0) begin
          // Owner refresh updates the value but never extends the dwell.
          holdCount_q <= holdCount_q - CW'(1);
          if (effReq[o_owner]) begin
            o_bits <= dataArr[o_owner];
            o_ack  <= 4'b0001 << o_owner;
          end
        end else begin
          state_q <= IDLE;
          o_busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_disp_share_arb.sv
// tb_disp_share_arb
// Directed, table-driven bench for disp_share_arb. One instance runs with a
// dwell of 4 cycles (contention, fairness, refresh, reset), a second with a
// dwell of 1 cycle (owners alternating every edge).
module tb_disp_share_arb;

  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'h2222_2222;
  localparam logic [31:0] D2 = 32'h3333_3333;
  localparam logic [31:0] D3 = 32'h4444_4444;
  localparam logic [31:0] DR = 32'h1234_5678;

  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] data3;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic [31:0] bits;
    logic        busy;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req4;
  logic [3:0]  req1;
  logic [31:0] data0, data1, data2, data3;
  logic [31:0] bits4, bits1;
  logic [1:0]  owner4, owner1;
  logic [3:0]  ack4, ack1;
  logic        busy4, busy1;

  int testsRun;
  int testsFailed;
  vec_t vecs[$];

  disp_share_arb #(.HOLD_CLOCKS(4)) dut4 (
    .clk(clk), .i_rst(rst), .i_req(req4),
    .i_data0(data0), .i_data1(data1), .i_data2(data2), .i_data3(data3),
    .o_bits(bits4), .o_owner(owner4), .o_ack(ack4), .o_busy(busy4)
  );

  disp_share_arb #(.HOLD_CLOCKS(1)) dut1 (
    .clk(clk), .i_rst(rst), .i_req(req1),
    .i_data0(data0), .i_data1(data1), .i_data2(data2), .i_data3(data3),
    .o_bits(bits1), .o_owner(owner1), .o_ack(ack1), .o_busy(busy1)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d3,
                              input logic [3:0] a, input logic [1:0] o,
                              input logic [31:0] b, input logic bz);
    vec_t v;
    v.req = r; v.data3 = d3; v.ack = a; v.owner = o; v.bits = b; v.busy = bz;
    return v;
  endfunction

  // Drive inputs, then step one rising edge and settle 1 unit past it.
  task automatic applyStimulus(input logic [3:0] r4, input logic [3:0] r1,
                               input logic [31:0] d3);
    req4  = r4;
    req1  = r1;
    data3 = d3;
    @(posedge clk);
    #1;
  endtask

  // Compare one instance's outputs against the expected values.
  task automatic checkOutput(input string name, input bit useDut1,
                             input logic [3:0] eAck, input logic [1:0] eOwner,
                             input logic [31:0] eBits, input logic eBusy);
    logic [3:0]  aAck;
    logic [1:0]  aOwner;
    logic [31:0] aBits;
    logic        aBusy;
    aAck   = useDut1 ? ack1   : ack4;
    aOwner = useDut1 ? owner1 : owner4;
    aBits  = useDut1 ? bits1  : bits4;
    aBusy  = useDut1 ? busy1  : busy4;
    testsRun++;
    if (aAck !== eAck || aOwner !== eOwner || aBits !== eBits || aBusy !== eBusy) begin
      testsFailed++;
      $display("[TB] FAIL %s: got ack=%b owner=%0d bits=%h busy=%b, expected ack=%b owner=%0d bits=%h busy=%b",
               name, aAck, aOwner, aBits, aBusy, eAck, eOwner, eBits, eBusy);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b1;
    req4  = 4'b0000;
    req1  = 4'b0000;
    data0 = D0;
    data1 = D1;
    data2 = D2;
    data3 = D3;

    // Full contention from reset: each requester drops on its own ack.
    vecs.push_back(mk(4'b1111, D3, 4'b0001, 2'd0, D0, 1'b1));
    vecs.push_back(mk(4'b1110, D3, 4'b0000, 2'd0, D0, 1'b1));
    vecs.push_back(mk(4'b1110, D3, 4'b0000, 2'd0, D0, 1'b1));
    vecs.push_back(mk(4'b1110, D3, 4'b0000, 2'd0, D0, 1'b1));
    vecs.push_back(mk(4'b1110, D3, 4'b0010, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b1100, D3, 4'b0000, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b1100, D3, 4'b0000, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b1100, D3, 4'b0000, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b1100, D3, 4'b0100, 2'd2, D2, 1'b1));
    vecs.push_back(mk(4'b1000, D3, 4'b0000, 2'd2, D2, 1'b1));
    vecs.push_back(mk(4'b1000, D3, 4'b0000, 2'd2, D2, 1'b1));
    vecs.push_back(mk(4'b1000, D3, 4'b0000, 2'd2, D2, 1'b1));
    vecs.push_back(mk(4'b1000, D3, 4'b1000, 2'd3, D3, 1'b1));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd3, D3, 1'b1));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd3, D3, 1'b1));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd3, D3, 1'b1));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd3, D3, 1'b0));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd3, D3, 1'b0));
    // Fairness: owner 1 expires with 0 and 2 pending -> 2, then 0.
    vecs.push_back(mk(4'b0010, D3, 4'b0010, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b0101, D3, 4'b0000, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b0101, D3, 4'b0000, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b0101, D3, 4'b0000, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b0101, D3, 4'b0100, 2'd2, D2, 1'b1));
    vecs.push_back(mk(4'b0001, D3, 4'b0000, 2'd2, D2, 1'b1));
    vecs.push_back(mk(4'b0001, D3, 4'b0000, 2'd2, D2, 1'b1));
    vecs.push_back(mk(4'b0001, D3, 4'b0000, 2'd2, D2, 1'b1));
    vecs.push_back(mk(4'b0001, D3, 4'b0001, 2'd0, D0, 1'b1));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd0, D0, 1'b1));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd0, D0, 1'b1));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd0, D0, 1'b1));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd0, D0, 1'b0));
    // Owner refresh: owner 3 re-raises at counter 2; 1 waits for expiry.
    vecs.push_back(mk(4'b1000, D3, 4'b1000, 2'd3, D3, 1'b1));
    vecs.push_back(mk(4'b0000, D3, 4'b0000, 2'd3, D3, 1'b1));
    vecs.push_back(mk(4'b1010, DR, 4'b1000, 2'd3, DR, 1'b1));
    vecs.push_back(mk(4'b0010, DR, 4'b0000, 2'd3, DR, 1'b1));
    vecs.push_back(mk(4'b0010, DR, 4'b0010, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b0000, DR, 4'b0000, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b0000, DR, 4'b0000, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b0000, DR, 4'b0000, 2'd1, D1, 1'b1));
    vecs.push_back(mk(4'b0000, DR, 4'b0000, 2'd1, D1, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_state", 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, 4'b0000, vecs[i].data3);
      checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].ack, vecs[i].owner,
                  vecs[i].bits, vecs[i].busy);
    end

    // Reset asserted mid-HOLD between edges clears outputs immediately.
    applyStimulus(4'b0100, 4'b0000, DR);
    checkOutput("pre_reset_grant", 1'b0, 4'b0100, 2'd2, D2, 1'b1);
    applyStimulus(4'b0000, 4'b0000, DR);
    checkOutput("pre_reset_hold", 1'b0, 4'b0000, 2'd2, D2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
    @(posedge clk);
    #4;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0000, 4'b0000, DR);
      checkOutput($sformatf("idle_after_reset%0d", k), 1'b0, 4'b0000, 2'd0, 32'h0, 1'b0);
    end
    // Pointer restarts at 3, so requester 1 beats requester 3.
    applyStimulus(4'b1010, 4'b0000, DR);
    checkOutput("rearb_after_reset", 1'b0, 4'b0010, 2'd1, D1, 1'b1);

    // Dwell of 1: a single held pattern alternates owners every edge.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b0000, 4'b0011, DR);
      checkOutput($sformatf("hold1_cycle%0d", k), 1'b1,
                  (k % 2 == 0) ? 4'b0001 : 4'b0010,
                  (k % 2 == 0) ? 2'd0 : 2'd1,
                  (k % 2 == 0) ? D0 : D1, 1'b1);
    end
    applyStimulus(4'b0000, 4'b0000, DR);
    checkOutput("hold1_release", 1'b1, 4'b0000, 2'd1, D1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/disp_share_arb.md
# disp_share_arb

Round-robin arbiter that shares the 8-digit seven-segment display between four requesters. Each requester offers a 32-bit hex value with a level request. The arbiter grants one requester and latches its value onto `o_bits`, which feeds the display driver's `i_bits`. Each grant is held for a minimum dwell time so every message stays readable.

## Interface
Parameters:
- `HOLD_CLOCKS`, default 50_000_000: minimum dwell per grant in clk cycles; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_req`  in  4  level request per requester; bit k = requester k.
- `i_data0`..`i_data3`  in  32 each  value offered by requester k.
- `o_bits`  out  32  value currently displayed; registered.
- `o_owner`  out  2  index of the current or last owner; registered.
- `o_ack`  out  4  one-hot, one-cycle pulse: the requester's data was latched; registered.
- `o_busy`  out  1  high while in HOLD; registered.

## Operation
- Reset values (async, immediate):
  - `o_bits` = 0, `o_owner` = 0, `o_ack` = 0, `o_busy` = 0.
  - State = IDLE, counter = 0, round-robin pointer `last` = 3, so requester 0 has top priority first.
- Effective request: `eff = i_req & ~o_ack`. This masks the requester acked in the current cycle, so a requester that drops `i_req` on the edge after seeing `o_ack` is never double-acked.
- Priority order: `last+1`, `last+2`, `last+3`, `last` (mod 4). The first set bit of `eff` in that order wins.
- States:
  - **IDLE**
    - If `eff` is nonzero: grant winner w.
      - `o_bits <= i_data[w]`, `o_owner <= w`, `last <= w`.
      - `o_ack <= onehot(w)`, `o_busy <= 1`, counter `<= HOLD_CLOCKS-1`, go to HOLD.
    - Otherwise: stay in IDLE; `o_bits` and `o_owner` keep the last value.
  - **HOLD**, counter ≠ 0
    - Counter decrements.
    - Owner refresh: if `eff[o_owner]` is set, `o_bits <= i_data[o_owner]` and `o_ack <= onehot(o_owner)`. The counter is not reloaded.
    - Other requesters wait; no ack.
  - **HOLD**, counter = 0 (expiry)
    - If `eff` is nonzero: re-arbitrate exactly as in IDLE (back-to-back grant) and stay in HOLD with the counter reloaded. The previous owner has lowest priority.
    - Otherwise: `o_busy <= 0`, go to IDLE.
- `o_ack` is cleared to 0 on every edge that does not set it.
- A requester holding `i_req` high continuously is re-acked every second cycle (refresh in HOLD, or a new grant). This is legal; requesters drop `i_req` after seeing ack.
- The counter width is `$clog2(HOLD_CLOCKS+1)`. The decrement never wraps, because the expiry branch is taken at 0.
- Reset asserted mid-HOLD returns all state to reset values asynchronously. Pending requests are re-arbitrated from `last` = 3 after release.

## Timing
- Grant latency: `i_req[k]` high before edge E with the arbiter in IDLE gives `o_ack[k]`, `o_bits`, `o_owner` and `o_busy` valid in the cycle after E (1-cycle latency).
- Dwell: grant at edge E0 gives expiry at edge E0+`HOLD_CLOCKS`. The next owner's ack appears after that edge, so owner changes are exactly `HOLD_CLOCKS` cycles apart under continuous contention.
- With `HOLD_CLOCKS` = 1, grants occur on every edge. Masking by `o_ack` alternates owners even when only one requester holds `i_req`.
- Refresh latency: 1 cycle; `o_bits` changes without any gap in `o_busy`.
- The combinational path is `i_req` → winner → output registers only; no input → output combinational path.

## Test plan
- **Reset:** assert `i_rst` mid-HOLD between edges. All outputs must go to 0 immediately, without waiting for a clock edge. After release with `i_req` = 4'b0000, IDLE persists and `o_busy` stays 0.
- **Single request:** `HOLD_CLOCKS` = 4, `i_req[2]` pulsed one cycle, `i_data2` = 0xDEADBEEF.
  - `o_ack` = 4'b0100 for exactly 1 cycle; `o_bits` = 0xDEADBEEF; `o_owner` = 2.
  - `o_busy` high for 4 cycles, then low.
  - `o_bits` holds 0xDEADBEEF afterwards.
- **Full contention from reset:** `i_req` = 4'b1111 held, `i_data`k = 0x1111_1111·(k+1), `HOLD_CLOCKS` = 4. Each requester drops its own req on seeing its ack.
  - Grants in order 0, 1, 2, 3, spaced exactly 4 cycles apart.
  - `o_busy` never drops until the last dwell ends.
- **Fairness:** after owner 1 expires with requests 0 and 2 pending, the next grant must be 2, then 0.
- **Owner refresh:** owner 3 in HOLD with counter = 2 re-raises `i_req[3]` for 1 cycle with `i_data3` = 0x12345678.
  - `o_ack[3]` pulses once and `o_bits` = 0x12345678 on the next cycle.
  - Expiry is unchanged (no dwell extension); `i_req[1]`, pending meanwhile, is granted at the original expiry.
- **Boundary `HOLD_CLOCKS` = 1:** `i_req` = 4'b0011 held continuously. Owners alternate 0, 1, 0, 1 on consecutive cycles, with `o_ack` one-hot every cycle.
